// File: rtl/sort_pkg.sv
// Shared definitions for the sort datapath: float field layout, FSM encoding and
// the total-order key used for comparing IEEE-style words as plain unsigned values.
package sort_pkg;
  localparam int NK    = 23;
  localparam int M     = 8;
  localparam int L     = NK + M + 1;
  localparam int K_DEF = 10;

  typedef logic [L-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Negatives invert fully, positives flip the sign bit: -0 lands just below +0.
  function automatic word_t order_key(input word_t w);
    return w ^ {1'b1, {(L-1){w[L-1]}}};
  endfunction
endpackage

// File: rtl/sort_frame_buf.sv
// K-entry frame store: one write port, one registered read port.
module sort_frame_buf
  import sort_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int AW = $clog2(K) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [L-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [L-1:0]  rd_data
);
  word_t mem [K];
  word_t rd_word;

  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++)
      if (wr_en && wr_addr == AW'(i)) mem[i] <= wr_data;
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < K; i++)
      if (rd_addr == AW'(i)) rd_word = mem[i];
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= rd_word;
  end
endmodule

// File: rtl/sort_result_drain.sv
// Captures one sorted frame from the free-running shell, flags order violations,
// then replays the frame on a valid/ready stream so a slow consumer may stall.
module sort_result_drain
  import sort_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int CW = $clog2(K) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [L-1:0]  in_word,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [L-1:0]  m_data,
  output logic          m_last,
  output logic          order_err,
  output logic          overrun,
  output logic          busy,
  output logic [CW-1:0] fill_cnt
);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_e        state;
  logic [CW-1:0] wr, rd;
  word_t         prev_key, key_in;
  logic          wr_en, rd_en;
  logic [CW-1:0] wr_addr, rd_addr;

  assign key_in  = order_key(in_word);
  assign wr_en   = in_valid && !reset && (state == ST_IDLE || state == ST_FILL);
  assign wr_addr = (state == ST_IDLE) ? '0 : wr;
  // Prefetch the next element so m_data always shows buf[rd] when m_valid is up.
  assign rd_en   = (state == ST_DRAIN) && (!m_valid || (m_ready && rd != LAST));
  assign rd_addr = m_valid ? rd + CW'(1) : '0;
  assign busy    = (state != ST_IDLE);

  sort_frame_buf #(.K(K), .AW(CW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_word),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (m_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr        <= '0;
      rd        <= '0;
      fill_cnt  <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      order_err <= 1'b0;
      overrun   <= 1'b0;
      prev_key  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FILL: begin
          if (in_valid) begin
            wr       <= (wr_addr == LAST) ? LAST : wr_addr + CW'(1);
            fill_cnt <= wr_addr + CW'(1);
            prev_key <= key_in;
            if (state == ST_IDLE)       order_err <= 1'b0;
            else if (key_in < prev_key) order_err <= 1'b1;
            state <= (wr_addr == LAST) ? ST_DRAIN : ST_FILL;
          end
        end
        ST_DRAIN: begin
          if (in_valid) overrun <= 1'b1;
          if (!m_valid) begin
            m_valid <= 1'b1;
            rd      <= '0;
            m_last  <= (LAST == '0);
          end else if (m_ready) begin
            if (rd == LAST) begin
              state    <= ST_IDLE;
              m_valid  <= 1'b0;
              m_last   <= 1'b0;
              fill_cnt <= '0;
              rd       <= '0;
              wr       <= '0;
            end else begin
              rd     <= rd + CW'(1);
              m_last <= (rd + CW'(1) == LAST);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_result_drain.sv
// Randomized bench for sort_result_drain (K=10 main instance plus a K=1 instance).
module tb_sort_result_drain;
  import sort_pkg::*;

  localparam int KM = 10;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        reset, in_valid, m_ready, m_valid, m_last, order_err, overrun, busy;
  logic [31:0] in_word, m_data;
  logic [4:0]  fill_cnt;

  logic        in_valid1, m_ready1, m_valid1, m_last1, order_err1, overrun1, busy1;
  logic [31:0] in_word1, m_data1;
  logic [0:0]  fill_cnt1;

  sort_result_drain #(.K(KM)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .order_err(order_err), .overrun(overrun), .busy(busy), .fill_cnt(fill_cnt)
  );

  sort_result_drain #(.K(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_word(in_word1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1),
    .order_err(order_err1), .overrun(overrun1), .busy(busy1), .fill_cnt(fill_cnt1)
  );

  int    n_chk = 0, n_fail = 0;
  bit    exp_ovr = 0;
  word_t frame_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Float ordering from sign/magnitude: any negative (incl. -0) below any positive.
  function automatic bit ref_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic bit ref_err();
    for (int i = 1; i < frame_q.size(); i++)
      if (ref_less(frame_q[i], frame_q[i-1])) return 1;
    return 0;
  endfunction

  task automatic rand_frame(input bit sorted);
    logic [31:0] t;
    frame_q.delete();
    for (int i = 0; i < KM; i++) frame_q.push_back($urandom());
    if (sorted)
      for (int i = 1; i < KM; i++)
        for (int j = i; j > 0 && ref_less(frame_q[j], frame_q[j-1]); j--) begin
          t = frame_q[j]; frame_q[j] = frame_q[j-1]; frame_q[j-1] = t;
        end
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      chk("fill_cnt", 64'(fill_cnt), 64'(i));
      in_valid = 1; in_word = frame_q[i];
      if (gap > 0 && i != frame_q.size() - 1) begin
        @(negedge clk); in_valid = 0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk); in_valid = 0;
    chk("pre_valid", 64'(m_valid), 0);
    chk("busy_fill", 64'(busy), 1);
    chk("fill_full", 64'(fill_cnt), KM);
    chk("order_err", 64'(order_err), 64'(ref_err()));
  endtask

  task automatic drain(input bit rnd_ready, input bit inject);
    int beats = 0, cyc = 0;
    bit stall = 0, injected = 0, rdy;
    logic [31:0] held = 0;
    while (beats < KM) begin
      @(negedge clk);
      if (++cyc > 400) begin chk("drain_timeout", 0, 1); break; end
      chk(cyc == 1 ? "latency" : "m_valid", 64'(m_valid), 1);
      if (stall) chk("stall_stable", 64'(m_data), 64'(held));
      in_valid = 0;
      if (inject && beats == 3 && !injected) begin
        in_valid = 1; in_word = $urandom(); injected = 1; exp_ovr = 1;
      end
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready = rdy;
      if (m_valid && rdy) begin
        chk("m_data", 64'(m_data), 64'(frame_q[beats]));
        chk("m_last", 64'(m_last), 64'(beats == KM - 1));
        beats++;
      end
      stall = m_valid && !rdy;
      held  = m_data;
    end
    @(negedge clk);
    in_valid = 0; m_ready = 0;
    chk("end_valid", 64'(m_valid), 0);
    chk("end_busy", 64'(busy), 0);
    chk("end_fill", 64'(fill_cnt), 0);
    chk("overrun", 64'(overrun), 64'(exp_ovr));
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    exp_ovr = 0;
  endtask

  task automatic k1_frame(input logic [31:0] w, input int stall_cycles);
    @(negedge clk); in_valid1 = 1; in_word1 = w;
    @(negedge clk); in_valid1 = 0;
    chk("k1_pre_valid", 64'(m_valid1), 0);
    chk("k1_fill", 64'(fill_cnt1), 1);
    repeat (stall_cycles + 1) begin
      @(negedge clk);
      chk("k1_valid", 64'(m_valid1), 1);
      chk("k1_data", 64'(m_data1), 64'(w));
      chk("k1_last", 64'(m_last1), 1);
    end
    m_ready1 = 1;
    @(negedge clk); m_ready1 = 0;
    chk("k1_end_valid", 64'(m_valid1), 0);
    chk("k1_busy", 64'(busy1), 0);
    chk("k1_order_err", 64'(order_err1), 0);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_word = 0; m_ready = 0;
    in_valid1 = 0; in_word1 = 0; m_ready1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(m_valid), 0);
    chk("rst_last", 64'(m_last), 0);
    chk("rst_data", 64'(m_data), 0);
    chk("rst_order", 64'(order_err), 0);
    chk("rst_overrun", 64'(overrun), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_fill", 64'(fill_cnt), 0);
    reset = 0;

    // 1.0 .. 10.0 back-to-back, full-rate drain
    frame_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    send_frame(0); drain(0, 0);

    // mixed signs incl. -0 before +0, then with 0.25 and -3.5 swapped
    frame_q = '{32'hC0600000, 32'h80000000, 32'h00000000, 32'h3E800000, 32'h40E00000,
                32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
    send_frame(0); drain(0, 0);
    frame_q[0] = 32'h3E800000; frame_q[3] = 32'hC0600000;
    send_frame(0); drain(1, 0);

    // random sorted frames with random backpressure
    repeat (3) begin rand_frame(1); send_frame(0); drain(1, 0); end

    // in_valid during drain: overrun sticks, data intact, next frame fine
    rand_frame(1); send_frame(0); drain(1, 1);
    rand_frame(1); send_frame(0); drain(0, 0);

    // reset mid-fill after 4 unordered words, then a clean frame
    pulse_reset();
    chk("ovr_cleared", 64'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1; in_word = 32'h41000000 - 32'(i << 20);
    end
    @(negedge clk); in_valid = 0;
    chk("part_fill", 64'(fill_cnt), 4);
    chk("part_err", 64'(order_err), 1);
    pulse_reset();
    chk("abort_busy", 64'(busy), 0);
    chk("abort_fill", 64'(fill_cnt), 0);
    chk("abort_err", 64'(order_err), 0);
    rand_frame(1); send_frame(0); drain(1, 0);

    // in_valid coincident with reset is ignored
    @(negedge clk); reset = 1; in_valid = 1; in_word = 32'h3F800000;
    @(negedge clk); reset = 0; in_valid = 0;
    chk("rst_win_busy", 64'(busy), 0);
    chk("rst_win_fill", 64'(fill_cnt), 0);

    // gapped input, one word every third cycle
    rand_frame(1); send_frame(2); drain(1, 0);

    // random, mostly unordered frames
    repeat (3) begin rand_frame(0); send_frame(0); drain(1, 0); end

    // K=1 instance
    k1_frame(32'hC0600000, 0);
    k1_frame($urandom(), 3);
    k1_frame($urandom(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
